fp_div_round_pack: RTL

- Output stage directly downstream of the fpdiv quotient datapath.
- Accepts the unrounded quotient as sign, unbiased exponent, a normalized 26-bit mantissa with guard/round bits, and a sticky flag.
- Performs denormal alignment, round-to-nearest-even, post-round renormalization and IEEE-754 single packing, and classifies the result into the 2-bit EXCEPTION code.
- Replaces the truncating, guard-bit-less result path with a handshaked, multi-cycle rounding stage.

---
 rtl/fp_div_pkg.sv | 22 ++
 rtl/fp_sticky_shifter.sv | 28 ++
 rtl/fp_div_round_pack.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, exception codes and FSM state type for the fpdiv output stage.
package fp_div_pkg;

  localparam int unsigned BIAS    = 127;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FFFFFFF;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_UF   = 2'b01,
    EXC_OF   = 2'b10,
    EXC_INV  = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StRound,
    StHold
  } state_e;

endpackage

// File: rtl/fp_sticky_shifter.sv
// Combinational right shift of the mantissa by a saturating 5-bit amount.
// Bits shifted out are ORed into o_sticky; amounts >= W clear the mantissa.
module fp_sticky_shifter #(
  parameter int unsigned W = 26
) (
  input  logic [W-1:0] i_mant,
  input  logic [4:0]   i_shamt,
  output logic [W-1:0] o_mant,
  output logic         o_sticky
);

  logic [W-1:0] w_mask;

  // Shift and collect the discarded bits.
  always_comb begin
    o_mant   = '0;
    o_sticky = 1'b0;
    w_mask   = '0;
    if (32'(i_shamt) >= W) begin
      o_sticky = |i_mant;
    end else begin
      o_mant   = i_mant >> i_shamt;
      w_mask   = ~({W{1'b1}} << i_shamt);
      o_sticky = |(i_mant & w_mask);
    end
  end

endmodule

// File: rtl/fp_div_round_pack.sv
// fpdiv output stage: denormal alignment, round-to-nearest-even, renormalization,
// IEEE-754 single packing and exception classification behind a valid/ready handshake.
// Optional macro FP_DIV_FTZ_EN: flush every result with a zero exponent field to
// signed zero (EXCEPTION=01) and bypass the denormal shifter.
module fp_div_round_pack
  import fp_div_pkg::*;
#(
  parameter int unsigned UEXP_W   = 10,
  parameter int unsigned FRAC_W   = 23,
  parameter int unsigned EXP_BITS = 8
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [UEXP_W-1:0]          in_uexp,
  input  logic [FRAC_W+2:0]          in_mant,
  input  logic                       in_sticky,
  input  logic                       in_special,
  input  logic [EXP_BITS+FRAC_W:0]   in_special_word,
  input  logic [1:0]                 in_special_exc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_BITS+FRAC_W:0]   AbyB,
  output logic [1:0]                 EXCEPTION
);

  localparam int unsigned MW = FRAC_W + 3;
  localparam int unsigned WW = 1 + EXP_BITS + FRAC_W;
  localparam logic signed [10:0] W_EMAX = 11'((1 << EXP_BITS) - 1);

  state_e r_state, w_state_d;

  logic                 r_sign;
  logic                 r_sticky;
  logic [MW-1:0]        r_mant;
  logic signed [10:0]   r_exp;
  logic [WW-1:0]        r_word;
  logic [1:0]           r_exc;

  logic signed [10:0]   w_e_in;
  logic                 w_ovf;
  logic                 w_den;

  // Biased exponent, sign-extended to 11 bits so it never wraps.
  assign w_e_in = {{(11 - UEXP_W){in_uexp[UEXP_W-1]}}, in_uexp} + 11'(BIAS);
  assign w_ovf  = (r_exp >= W_EMAX);
  assign w_den  = (r_exp <= 11'sd0);

`ifndef FP_DIV_FTZ_EN
  logic signed [10:0]   w_shamt_wide;
  logic [4:0]           w_shamt;
  logic [MW-1:0]        w_sh_mant;
  logic                 w_sh_sticky;

  assign w_shamt_wide = 11'sd1 - r_exp;
  assign w_shamt      = (w_shamt_wide > 11'sd31) ? 5'd31 : w_shamt_wide[4:0];

  fp_sticky_shifter #(
    .W (MW)
  ) u_shifter (
    .i_mant   (r_mant),
    .i_shamt  (w_shamt),
    .o_mant   (w_sh_mant),
    .o_sticky (w_sh_sticky)
  );
`endif

  // Rounding datapath (used in ROUND).
  logic                 w_lsb, w_g, w_st, w_up, w_inexact;
  logic [FRAC_W+1:0]    w_sum;
  logic signed [10:0]   w_rexp;
  logic [FRAC_W-1:0]    w_frac;
  logic [WW-1:0]        w_rnd_word;
  logic [1:0]           w_rnd_exc;

  assign w_lsb     = r_mant[2];
  assign w_g       = r_mant[1];
  assign w_st      = r_mant[0] | r_sticky;
  assign w_up      = w_g & (w_st | w_lsb);
  assign w_inexact = w_g | w_st;
  assign w_sum     = {1'b0, r_mant[MW-1:2]} + {{(FRAC_W + 1){1'b0}}, w_up};

  // Renormalize after the increment and classify the packed result.
  always_comb begin
    w_rexp     = r_exp;
    w_frac     = w_sum[FRAC_W-1:0];
    w_rnd_word = '0;
    w_rnd_exc  = EXC_NONE;
    if (r_exp == 11'sd0) begin
      // Denormal: a carry into the hidden position promotes to the smallest normal.
      w_rexp = {10'b0, w_sum[FRAC_W]};
    end else if (w_sum[FRAC_W+1]) begin
      w_rexp = r_exp + 11'sd1;
      w_frac = w_sum[FRAC_W:1];
    end
`ifdef FP_DIV_FTZ_EN
    if (r_exp == 11'sd0) begin
      w_rnd_word = {r_sign, {(WW - 1){1'b0}}};
      w_rnd_exc  = EXC_UF;
    end else
`endif
    if (w_rexp >= W_EMAX) begin
      w_rnd_word = {r_sign, {EXP_BITS{1'b1}}, {FRAC_W{1'b0}}};
      w_rnd_exc  = EXC_OF;
    end else begin
      w_rnd_word = {r_sign, w_rexp[EXP_BITS-1:0], w_frac};
      w_rnd_exc  = ((w_rexp == 11'sd0) && w_inexact) ? EXC_UF : EXC_NONE;
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = in_special ? StHold : StAlign;
      StAlign: w_state_d = w_ovf ? StHold : StRound;
      StRound: w_state_d = StHold;
      StHold:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Operand capture, alignment and result registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_word   <= '0;
      r_exc    <= EXC_NONE;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sign   <= in_sign;
            r_mant   <= in_mant;
            r_sticky <= in_sticky;
            r_exp    <= w_e_in;
            if (in_special) begin
              r_word <= in_special_word;
              r_exc  <= in_special_exc;
            end
          end
        end
        StAlign: begin
          if (w_ovf) begin
            r_word <= {r_sign, {EXP_BITS{1'b1}}, {FRAC_W{1'b0}}};
            r_exc  <= EXC_OF;
          end else if (w_den) begin
`ifdef FP_DIV_FTZ_EN
            r_exp    <= 11'sd0;
`else
            r_mant   <= w_sh_mant;
            r_sticky <= r_sticky | w_sh_sticky;
            r_exp    <= 11'sd0;
`endif
          end
        end
        StRound: begin
          r_word <= w_rnd_word;
          r_exc  <= w_rnd_exc;
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs.
  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StHold);
  assign AbyB      = r_word;
  assign EXCEPTION = r_exc;

endmodule
